serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller. Sequences a single Full_Adder cell (ports a, b, cin, cout, sum)

---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is stepped over WIDTH cycles,
// LSB first, with a registered carry between bits.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_init,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Handshake: start is sampled only in IDLE; the edge that sees it high
   // captures op_a/op_b/cin_init. done is a one-cycle pulse WIDTH edges later,
   // with result/cout already valid; start is ignored until back in IDLE.
   state_t           state, state_nxt;
   logic             accept;
   logic [WIDTH-1:0] sa, sb;
   logic             c;
   logic [KW-1:0]    k;
   logic             last_bit;
   logic             fa_a, fa_b, fa_cin, fa_sum, fa_cout;
   logic [WIDTH-1:0] sum_vec;

   assign fa_a     = sa[0];
   assign fa_b     = sb[0];
   assign fa_cin   = c;
   assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
   assign last_bit = (k == KW'(WIDTH - 1));

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end
         RUN:  if (last_bit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // sum_vec is the current sum bit stacked on the bits already collected,
   // so the final edge can load result without a separate shift.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_vec = fa_sum;
      end else begin : g_wn
         logic [WIDTH-2:0] sr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)             sr <= '0;
            else if (state == RUN)  sr <= sum_vec[WIDTH-1:1];
         end
         assign sum_vec = {fa_sum, sr};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         c      <= 1'b0;
         k      <= '0;
         result <= '0;
         cout   <= 1'b0;
      end else if (accept) begin
         sa <= op_a;
         sb <= op_b;
         c  <= cin_init;
         k  <= '0;
      end else if (state == RUN) begin
         sa <= sa >> 1;
         sb <= sb >> 1;
         c  <= fa_cout;
         k  <= k + 1'b1;
         if (last_bit) begin
            result <= sum_vec;
            cout   <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit and a 1-bit instance, with a
// scoreboard queue of expected {cout,result} values popped on each done pulse.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start, cin_init;
   logic [W-1:0] op_a, op_b;
   logic         busy, done, cout;
   logic [W-1:0] result;

   logic         start1, a1, b1, cin1;
   logic         busy1, done1, cout1;
   logic [0:0]   result1;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           done_cnt = 0;
   logic [W:0]   exp_q[$];
   logic [1:0]   exp1_q[$];
   logic [W:0]   last_res;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .cin_init(cin_init), .busy(busy), .done(done), .result(result), .cout(cout)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1),
      .cin_init(cin1), .busy(busy1), .done(done1), .result(result1), .cout(cout1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every done pulse must match the oldest pending request
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         check("w8_pending_at_done", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("w8_sum", 32'({cout, result}), 32'(exp_q.pop_front()));
      end
      if (done1 === 1'b1) begin
         check("w1_pending_at_done", 32'(exp1_q.size() > 0), 32'd1);
         if (exp1_q.size() > 0) check("w1_sum", 32'({cout1, result1}), 32'(exp1_q.pop_front()));
      end
   end

   // driver: one add on the 8-bit instance, checking busy/done timing and that
   // result/cout stay at the previous value while the add is in flight
   task automatic do_add8(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      logic [W:0] e;
      e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      @(negedge clk);
      op_a = a; op_b = b; cin_init = ci; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("w8_busy_run", 32'(busy), 32'd1);
         check("w8_done_run", 32'(done), 32'd0);
         check("w8_result_held", 32'({cout, result}), 32'(last_res));
      end
      @(negedge clk);
      check("w8_done_pulse", 32'(done), 32'd1);
      check("w8_busy_in_done", 32'(busy), 32'd0);
      last_res = e;
      @(negedge clk);
      check("w8_done_one_cycle", 32'(done), 32'd0);
      check("w8_result_stable", 32'({cout, result}), 32'(e));
   endtask

   task automatic do_add1(input logic a, input logic b, input logic ci);
      logic [1:0] e;
      e = {1'b0, a} + {1'b0, b} + {1'b0, ci};
      @(negedge clk);
      a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
      exp1_q.push_back(e);
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      check("w1_busy", 32'(busy1), 32'd1);
      check("w1_done_early", 32'(done1), 32'd0);
      @(negedge clk);
      check("w1_done_pulse", 32'(done1), 32'd1);
      @(negedge clk);
      check("w1_done_one_cycle", 32'(done1), 32'd0);
   endtask

   initial begin
      int         base_cnt;
      int         dc[$];
      logic       busy_lo[40];
      int         lows;

      rst_n = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin_init = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      last_res = '0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'({cout, result}), 32'd0);
      check("rst_w1", 32'({busy1, done1, cout1, result1}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic add plus carry/boundary patterns
      do_add8(8'h5A, 8'h3C, 1'b0);
      do_add8(8'hFF, 8'h01, 1'b0);
      do_add8(8'hFF, 8'hFF, 1'b1);
      do_add8(8'h00, 8'h00, 1'b0);
      do_add8(8'h80, 8'h7F, 1'b1);

      // second request and operand churn during an add in flight
      base_cnt = done_cnt;
      @(negedge clk);
      op_a = 8'h10; op_b = 8'h20; cin_init = 1'b0; start = 1'b1;
      exp_q.push_back(9'h030);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         op_a = (i == 2) ? 8'hAA : 8'($urandom_range(0, 255));
         op_b = (i == 2) ? 8'h55 : 8'($urandom_range(0, 255));
         cin_init = 1'($urandom_range(0, 1));
         start = (i == 2);
      end
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("ignored_start_done_count", 32'(done_cnt - base_cnt), 32'd1);
      check("ignored_start_busy", 32'(busy), 32'd0);
      check("ignored_start_result", 32'({cout, result}), 32'h030);

      // start held high: back-to-back adds every WIDTH+2 cycles
      op_a = 8'h33; op_b = 8'h44; cin_init = 1'b1; start = 1'b1;
      repeat (3) exp_q.push_back(9'h078);
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (done === 1'b1) dc.push_back(t);
         busy_lo[t] = (busy !== 1'b1);
         if (dc.size() >= 2 && busy === 1'b1) start = 1'b0;
      end
      start = 1'b0;
      check("held_done_count", 32'(dc.size()), 32'd3);
      if (dc.size() >= 3) begin
         check("held_gap_1", 32'(dc[1] - dc[0]), 32'd10);
         check("held_gap_2", 32'(dc[2] - dc[1]), 32'd10);
         lows = 0;
         for (int t = dc[0]; t < dc[1]; t++) lows += int'(busy_lo[t]);
         check("held_busy_low_cycles", 32'(lows), 32'd2);
      end

      // asynchronous reset in the middle of a run
      @(negedge clk);
      op_a = 8'h12; op_b = 8'h34; cin_init = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", 32'(busy), 32'd0);
      check("midrun_rst_done", 32'(done), 32'd0);
      check("midrun_rst_result", 32'({cout, result}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
      do_add8(8'h01, 8'h01, 1'b0);

      // 1-bit instance: full-adder truth table
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = 3'(v);
         do_add1(vv[2], vv[1], vv[0]);
      end

      repeat (3) @(negedge clk);
      check("w8_queue_drained", 32'(exp_q.size()), 32'd0);
      check("w1_queue_drained", 32'(exp1_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
